// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK register sequencer: command opcodes and controller states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle; async active-low clear.
module jk_cell (
  input  logic Clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving a bank of JK cells: hold/up/down/load for a programmed edge count.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module jk_seq_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LW    = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LW-1:0]    cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             tc,
  output logic             done,
  output state_t           dbg_state
);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic [LW-1:0]    remaining;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] down_t;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= OP_HOLD;
      data_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_t'(cmd_op);
            data_q <= cmd_data;
            if (op_t'(cmd_op) == OP_LOAD) begin
              remaining <= LW'(1);
              state     <= S_RUN;
            end else if (cmd_len == '0) begin
              // Zero-length command completes without touching Q.
              remaining <= '0;
              state     <= S_DONE;
            end else begin
              remaining <= cmd_len;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          remaining <= remaining - LW'(1);
          if (remaining == LW'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Prefix ANDs give the toggle condition of each bit for binary up/down counting.
  always_comb begin
    up_t      = '0;
    down_t    = '0;
    up_t[0]   = 1'b1;
    down_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i]   = up_t[i-1] & Q[i-1];
      down_t[i] = down_t[i-1] & ~Q[i-1];
    end
  end

  always_comb begin
    J = '0;
    K = '0;
    if (state == S_RUN) begin
      case (op_q)
        OP_UP:   begin J = up_t;   K = up_t;    end
        OP_DOWN: begin J = down_t; K = down_t;  end
        OP_LOAD: begin J = data_q; K = ~data_q; end
        default: begin J = '0;     K = '0;      end
      endcase
    end
  end

  assign tc        = (state == S_RUN) &&
                     ((op_q == OP_UP && (&Q)) || (op_q == OP_DOWN && (Q == '0)));
  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .Clk (Clk),
      .rst (rst),
      .J   (J[g]),
      .K   (K[g]),
      .Q   (Q[g])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed self-checking bench for jk_seq_ctrl with hand-computed expectations.
module tb_jk_seq_ctrl;
  import jk_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int LW    = 8;

  logic             Clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LW-1:0]    cmd_len;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             tc;
  logic             done;
  state_t           dbg_state;

  int total = 0;
  int bad   = 0;

  jk_seq_ctrl #(.WIDTH(WIDTH), .LW(LW)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .Q         (Q),
    .J         (J),
    .K         (K),
    .tc        (tc),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a command starting 1 time unit after an edge in IDLE; returns 1 unit after the accept edge.
  task automatic run_cmd(input logic [1:0] op, input logic [LW-1:0] len,
                         input logic [WIDTH-1:0] data, input bit keep_valid);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge Clk);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    cmd_data  = '0;

    // 1. reset state
    #3;
    check("rst_q", 32'(Q), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_j", 32'(J), 32'h0);
    check("rst_k", 32'(K), 32'h0);
    check("rst_tc", 32'(tc), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge Clk);
    rst = 1'b1;
    step();

    // 2. UP len 5 from 0
    run_cmd(2'b01, 8'd5, 4'h0, 1'b0);
    check("up_accept_ready", 32'(cmd_ready), 32'h0);
    check("up_accept_j", 32'(J), 32'h1);
    check("up_accept_k", 32'(K), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("up_q", 32'(Q), 32'(k));
      check("up_done", 32'(done), (k == 5) ? 32'h1 : 32'h0);
    end
    step();
    check("up_done_end", 32'(done), 32'h0);
    check("up_ready_end", 32'(cmd_ready), 32'h1);
    check("up_q_hold", 32'(Q), 32'h5);

    // 3. LOAD E then UP across wrap
    run_cmd(2'b11, 8'd0, 4'hE, 1'b0);
    check("load_j", 32'(J), 32'hE);
    check("load_k", 32'(K), 32'h1);
    step();
    check("load_q", 32'(Q), 32'hE);
    check("load_done", 32'(done), 32'h1);
    step();
    check("load_ready", 32'(cmd_ready), 32'h1);
    run_cmd(2'b01, 8'd3, 4'h0, 1'b0);
    check("wrap_tc0", 32'(tc), 32'h0);
    step();
    check("wrap_q1", 32'(Q), 32'hF);
    check("wrap_tc1", 32'(tc), 32'h1);
    step();
    check("wrap_q2", 32'(Q), 32'h0);
    check("wrap_tc2", 32'(tc), 32'h0);
    step();
    check("wrap_q3", 32'(Q), 32'h1);
    check("wrap_tc3", 32'(tc), 32'h0);
    check("wrap_done", 32'(done), 32'h1);
    step();

    // 4. DOWN across wrap from 0
    run_cmd(2'b11, 8'd0, 4'h0, 1'b0);
    step();
    step();
    check("dn_pre_q", 32'(Q), 32'h0);
    run_cmd(2'b10, 8'd2, 4'h0, 1'b0);
    check("dn_tc0", 32'(tc), 32'h1);
    check("dn_j0", 32'(J), 32'hF);
    step();
    check("dn_q1", 32'(Q), 32'hF);
    check("dn_tc1", 32'(tc), 32'h0);
    step();
    check("dn_q2", 32'(Q), 32'hE);
    check("dn_done", 32'(done), 32'h1);
    step();

    // 5. zero length and busy requests
    run_cmd(2'b00, 8'd0, 4'h0, 1'b0);
    check("len0_done", 32'(done), 32'h1);
    check("len0_q", 32'(Q), 32'hE);
    check("len0_ready", 32'(cmd_ready), 32'h0);
    step();
    check("len0_done_end", 32'(done), 32'h0);
    check("len0_ready_end", 32'(cmd_ready), 32'h1);
    run_cmd(2'b01, 8'd4, 4'h0, 1'b1);
    cmd_op   = 2'b11;
    cmd_data = 4'h3;
    for (int k = 1; k <= 4; k++) begin
      check("busy_ready", 32'(cmd_ready), 32'h0);
      step();
      check("busy_q", 32'(Q), 32'((14 + k) % 16));
    end
    check("busy_done", 32'(done), 32'h1);
    cmd_valid = 1'b0;
    step();
    check("busy_q_after", 32'(Q), 32'h2);
    check("busy_ready_after", 32'(cmd_ready), 32'h1);

    // 6. reset mid-command
    run_cmd(2'b11, 8'd0, 4'h0, 1'b0);
    step();
    step();
    run_cmd(2'b01, 8'd10, 4'h0, 1'b0);
    step();
    step();
    step();
    check("mid_q3", 32'(Q), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("mid_q_async", 32'(Q), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    check("mid_ready", 32'(cmd_ready), 32'h1);
    #1 rst = 1'b1;
    step();
    check("post_q", 32'(Q), 32'h0);
    check("post_done", 32'(done), 32'h0);
    check("post_ready", 32'(cmd_ready), 32'h1);
    run_cmd(2'b01, 8'd1, 4'h0, 1'b0);
    step();
    check("post_up_q", 32'(Q), 32'h1);
    check("post_up_done", 32'(done), 32'h1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_seq_ctrl.md
# jk_seq_ctrl

Command-driven sequencer for a WIDTH-bit register built from JK flip-flop cells. It accepts one command at a time over a valid/ready handshake: hold, count up, count down or parallel load, applied for a programmed number of clock edges. It computes the J/K excitation for every bit, drives the internal JK cell bank, and pulses `done` on completion. It is the control layer used wherever the design needs a JK-based counter or register under sequenced control.

## Interface
- `WIDTH`, 4: number of JK bits in the register.
- `LW`, 8: width of the command length field.

- `Clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain only.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_op`  in  2  00 HOLD, 01 UP, 10 DOWN, 11 LOAD.
- `cmd_len`  in  LW  number of edges the operation is applied; ignored for LOAD.
- `cmd_data`  in  WIDTH  load value for LOAD.
- `Q`  out  WIDTH  register contents.
- `J`  out  WIDTH  current J excitation, bit per cell.
- `K`  out  WIDTH  current K excitation, bit per cell.
- `tc`  out  1  terminal count.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE → RUN:** on an edge with `cmd_valid && cmd_ready`.
  - The edge latches op, data and remaining = `cmd_len` (LOAD: remaining = 1).
  - If `cmd_len == 0` and op ≠ LOAD, the edge goes IDLE → DONE directly and Q is untouched.
- **RUN:** excitation is applied combinationally from the latched op and the current Q.
  - HOLD: J = K = 0.
  - UP: J[i] = K[i] = &Q[i-1:0]; bit 0 is 1.
  - DOWN: J[i] = K[i] = &~Q[i-1:0]; bit 0 is 1.
  - LOAD: J = data, K = ~data.
  - Each RUN edge updates Q through the cells and decrements remaining.
  - When remaining == 1 at an edge, the next state is DONE.
- **DONE:** `done = 1` for exactly one cycle, then IDLE.
- **IDLE and DONE:** J = K = 0, so Q holds.
- **Wrap-around:** UP from all ones gives 0; DOWN from 0 gives all ones. Arithmetic is modulo 2^WIDTH.
- **tc:** high in RUN when (op == UP and Q == all ones) or (op == DOWN and Q == 0); otherwise 0. It is combinational from state, op and Q.
- **Busy behaviour:** `cmd_valid` outside IDLE is ignored and not queued. Command fields are sampled only on the accept edge.

## Timing
- **Reset values:** Q = 0, state IDLE, `cmd_ready` = 1, `done` = 0, J = K = 0, `tc` = 0, latched op = HOLD.
- **Reset asserted mid-command:** Q clears immediately, without waiting for a clock. The command is abandoned, no `done` is produced, and the block returns to IDLE on release.
- **Latency for len L ≥ 1:**
  - Accept at edge t0.
  - Q updates at edges t1…tL.
  - `done` is high in the cycle after tL.
  - `cmd_ready` rises after edge tL+1.
  - Command period is L + 2 cycles.
- **LOAD:** Q = data after t1, `done` after t1, period 3 cycles.
- **len = 0:** `done` in the cycle after t0, period 2 cycles.
- **Back-to-back commands:** a new command may be accepted on the first IDLE edge after DONE.

## Structure
- **Package `jk_ctrl_pkg`:**
  - `op_t` enum: OP_HOLD, OP_UP, OP_DOWN, OP_LOAD.
  - `state_t` enum: S_IDLE, S_RUN, S_DONE.
- **Sub-module `jk_cell`:** a single JK flip-flop with ports Q, J, K, Clk, rst.
  - Asynchronous active-low reset to 0.
  - Behaviour: 00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate. The controller never writes Q directly.

## Test plan
1. **Reset:** `rst` low from t=0 → Q = 0, `cmd_ready` = 1, `done` = 0, J = K = 0, `tc` = 0. Pulsing `rst` low again between clock edges clears Q immediately, without waiting for an edge.
2. **UP from reset:** UP, len 5 → Q = 1, 2, 3, 4, 5 on consecutive edges. `done` is high for one cycle after Q = 5, then `cmd_ready` = 1.
3. **LOAD then UP across wrap:** LOAD data 4'hE → Q = E. Then UP len 3 → Q = F, 0, 1. `tc` is high only while Q = F.
4. **DOWN across wrap:** DOWN len 2 from Q = 0 → Q = F, E. `tc` is high in the first RUN cycle (Q = 0).
5. **Zero length and busy requests:** HOLD len 0 → `done` in the cycle after accept, Q unchanged. `cmd_valid` held high during RUN of an UP len 4 is not accepted (`cmd_ready` = 0) and has no effect until IDLE.
6. **Reset mid-command:** `rst` asserted during RUN of UP len 10 at Q = 3 → Q = 0 immediately, no `done`. After release, `cmd_ready` = 1 and a new UP len 1 gives Q = 1.
